// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search used by the UART transmit arbiter.
package uart_arb_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int MAX_ID_WIDTH = 4;

  typedef enum logic [0:0] {
    STATE_IDLE  = 1'b0,
    STATE_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic                    found;
    logic [MAX_ID_WIDTH-1:0] idx;
  } rr_result_t;

  // First set bit of req searching upward from last_id+1, wrapping at num_ch.
  // last_id < num_ch and k <= num_ch, so one conditional subtraction wraps.
  function automatic rr_result_t rr_next(input logic [MAX_CHANNELS-1:0] req,
                                         input logic [MAX_ID_WIDTH-1:0] last_id,
                                         input int num_ch);
    rr_result_t res;
    logic [MAX_ID_WIDTH:0] cand;
    res.found = 1'b0;
    res.idx   = {MAX_ID_WIDTH{1'b0}};
    for (int k = 1; k <= MAX_CHANNELS; k++) begin
      cand = {1'b0, last_id} + (MAX_ID_WIDTH+1)'(k);
      if (cand >= (MAX_ID_WIDTH+1)'(num_ch)) begin
        cand = cand - (MAX_ID_WIDTH+1)'(num_ch);
      end
      if ((k <= num_ch) && !res.found && req[cand[MAX_ID_WIDTH-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_ID_WIDTH-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side stream bundle of the UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_WIDTH   = 8
);
  localparam int ID_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS*WORD_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CHANNELS-1:0]            s_axis_tvalid;
  logic [NUM_CHANNELS-1:0]            s_axis_tlast;
  logic [NUM_CHANNELS-1:0]            s_axis_tready;
  logic [NUM_CHANNELS-1:0]            chan_enable;
  logic [WORD_WIDTH-1:0]              m_axis_tdata;
  logic                               m_axis_tvalid;
  logic                               m_axis_tready;
  logic                               grant_valid;
  logic [ID_WIDTH-1:0]                grant_id;

  // Arbiter view.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, chan_enable, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_id
  );

  // Environment view: requesters plus transmitter.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, chan_enable, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_id
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker; thin wrapper over uart_arb_pkg::rr_next.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  localparam int ID_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic [ID_WIDTH-1:0]     i_last_id,
  output logic                    o_found,
  output logic [ID_WIDTH-1:0]     o_idx
);

  logic [MAX_CHANNELS-1:0] w_req_ext;
  logic [MAX_ID_WIDTH-1:0] w_last_ext;
  rr_result_t              w_res;

  // Widen to the package search width, search, narrow back to ID_WIDTH.
  always_comb begin
    w_req_ext                   = {MAX_CHANNELS{1'b0}};
    w_req_ext[NUM_CHANNELS-1:0] = i_req;
    w_last_ext                  = MAX_ID_WIDTH'(i_last_id);
    w_res                       = rr_next(w_req_ext, w_last_ext, NUM_CHANNELS);
    o_found                     = w_res.found;
    o_idx                       = ID_WIDTH'(w_res.idx);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART transmitter stream.
// Data/valid/ready paths are combinational through the granted channel, so
// words pass with no added latency once a grant is registered.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int WORD_WIDTH   = 8,
  parameter  int MAX_BURST    = 16,
  localparam int ID_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CNT_WIDTH    = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = STATE_IDLE;
  localparam logic [0:0] S_GRANT = STATE_GRANT;

  logic [0:0]              r_state;
  logic [ID_WIDTH-1:0]     r_grant_id;
  logic [ID_WIDTH-1:0]     r_last_id;
  logic [CNT_WIDTH-1:0]    r_burst_cnt;

  logic [NUM_CHANNELS-1:0] w_req;
  logic                    w_found;
  logic [ID_WIDTH-1:0]     w_pick;
  logic                    w_m_tvalid;
  logic [WORD_WIDTH-1:0]   w_m_tdata;
  logic [NUM_CHANNELS-1:0] w_s_tready;
  logic                    w_hs;
  logic                    w_release;

  // chan_enable only matters here, i.e. while choosing the next owner.
  assign w_req = bus.s_axis_tvalid & bus.chan_enable;

  rr_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_picker (
    .i_req     (w_req),
    .i_last_id (r_last_id),
    .o_found   (w_found),
    .o_idx     (w_pick)
  );

  // Route the granted channel to the transmitter; everything is quiet in IDLE.
  always_comb begin
    w_m_tvalid = 1'b0;
    w_m_tdata  = {WORD_WIDTH{1'b0}};
    w_s_tready = {NUM_CHANNELS{1'b0}};
    if (r_state == S_GRANT) begin
      w_m_tvalid             = bus.s_axis_tvalid[r_grant_id];
      w_m_tdata              = bus.s_axis_tdata[int'(r_grant_id)*WORD_WIDTH +: WORD_WIDTH];
      w_s_tready[r_grant_id] = bus.m_axis_tready;
    end else begin
      w_m_tvalid = 1'b0;
    end
  end

  assign w_hs      = w_m_tvalid & bus.m_axis_tready;
  assign w_release = w_hs & (bus.s_axis_tlast[r_grant_id] |
                             (r_burst_cnt == CNT_WIDTH'(MAX_BURST - 1)));

  // Grant FSM: pick in IDLE, hold until tlast or the burst limit is handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant_id  <= {ID_WIDTH{1'b0}};
      r_last_id   <= ID_WIDTH'(NUM_CHANNELS - 1);
      r_burst_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_grant_id  <= w_pick;
            r_burst_cnt <= {CNT_WIDTH{1'b0}};
          end
        end
        S_GRANT: begin
          if (w_hs) begin
            r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
          end
          if (w_release) begin
            r_state    <= S_IDLE;
            r_last_id  <= r_grant_id;
            r_grant_id <= {ID_WIDTH{1'b0}};
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_grant_id <= {ID_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.m_axis_tdata  = w_m_tdata;
  assign bus.s_axis_tready = w_s_tready;
  assign bus.grant_valid   = (r_state == S_GRANT);
  assign bus.grant_id      = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (4 channels, MAX_BURST=4).
module tb_uart_tx_arbiter;
  localparam int NCH = 4;
  localparam int WW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [8:0] src_q [NCH][$];   // per-channel source: {last, data}
  logic [9:0] exp_q [$];        // scoreboard: {grant_id, data}
  int         hs_cyc_q [$];     // cycle of every transmitter handshake

  logic [3:0] pk_req;
  logic [1:0] pk_last;
  logic       pk_found;
  logic [1:0] pk_idx;

  uart_tx_arbiter_if #(.NUM_CHANNELS(NCH), .WORD_WIDTH(WW)) bus ();

  uart_tx_arbiter #(.NUM_CHANNELS(NCH), .WORD_WIDTH(WW), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_picker #(.NUM_CHANNELS(NCH)) u_pick (
    .i_req     (pk_req),
    .i_last_id (pk_last),
    .o_found   (pk_found),
    .o_idx     (pk_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic load(input int ch, input logic [7:0] d, input logic last);
    src_q[ch].push_back({last, d});
  endtask

  task automatic expect_word(input int ch, input logic [7:0] d);
    exp_q.push_back({2'(ch), d});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Source models: retire the front word after a handshake, present the next.
  initial begin : src_drv
    logic [NCH-1:0] hs;
    bus.s_axis_tvalid = 4'b0000;
    bus.s_axis_tdata  = 32'h0000_0000;
    bus.s_axis_tlast  = 4'b0000;
    forever begin
      @(negedge clk);
      hs = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.s_axis_tvalid[i]        = 1'b1;
          bus.s_axis_tdata[i*WW +: WW] = src_q[i][0][7:0];
          bus.s_axis_tlast[i]         = src_q[i][0][8];
        end else begin
          bus.s_axis_tvalid[i]        = 1'b0;
          bus.s_axis_tdata[i*WW +: WW] = 8'h00;
          bus.s_axis_tlast[i]         = 1'b0;
        end
      end
    end
  end

  // Transmitter-side monitor: every accepted word must match the scoreboard head.
  initial begin : mon
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL unexpected_word: observed ch%0d data %0h expected no word",
                 bus.grant_id, bus.m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("word_data", bus.m_axis_tdata, e[7:0]);
          check("word_grant_id", bus.grant_id, e[9:8]);
          check("word_grant_valid", bus.grant_valid, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int t_start;
    int n;
    logic stable;

    bus.chan_enable   = 4'b1111;
    bus.m_axis_tready = 1'b1;
    pk_req  = 4'b0000;
    pk_last = 2'd0;

    // Reset state
    #2;
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_m_tvalid", bus.m_axis_tvalid, 0);
    check("rst_s_tready", bus.s_axis_tready, 0);
    check("rst_m_tdata", bus.m_axis_tdata, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Fairness: all channels request 1-word messages, ch0 has two
    base = hs_cyc_q.size();
    load(0, 8'hA0, 1'b1); load(0, 8'hA4, 1'b1);
    load(1, 8'hB1, 1'b1); load(2, 8'hC2, 1'b1); load(3, 8'hD3, 1'b1);
    expect_word(0, 8'hA0); expect_word(1, 8'hB1); expect_word(2, 8'hC2);
    expect_word(3, 8'hD3); expect_word(0, 8'hA4);
    wait_drain("t2_drain", 60);
    for (int k = 1; k < 5; k++) begin
      check("t2_idle_gap", hs_cyc_q[base+k] - hs_cyc_q[base+k-1], 2);
    end

    // Single channel, consecutive words, one cycle of arbitration latency
    base    = hs_cyc_q.size();
    t_start = cyc + 1;
    load(2, 8'h41, 1'b0); load(2, 8'h42, 1'b0); load(2, 8'h43, 1'b1);
    expect_word(2, 8'h41); expect_word(2, 8'h42); expect_word(2, 8'h43);
    wait_drain("t1_drain", 40);
    for (int k = 0; k < 3; k++) begin
      check("t1_word_cycle", hs_cyc_q[base+k], t_start + 1 + k);
    end
    check("t1_release_valid", bus.grant_valid, 0);
    check("t1_release_id", bus.grant_id, 0);

    // Burst limit: ch1 gets 4 words, pending ch3 cuts in, ch1 resumes
    for (int k = 0; k < 10; k++) load(1, 8'(8'h10 + k), (k == 9) ? 1'b1 : 1'b0);
    step(2);
    load(3, 8'h30, 1'b0); load(3, 8'h31, 1'b1);
    for (int k = 0; k < 4; k++) expect_word(1, 8'(8'h10 + k));
    expect_word(3, 8'h30); expect_word(3, 8'h31);
    for (int k = 4; k < 10; k++) expect_word(1, 8'(8'h10 + k));
    wait_drain("t3_drain", 120);

    // Backpressure mid-message for 1000 cycles
    load(0, 8'h50, 1'b0); load(0, 8'h51, 1'b0); load(0, 8'h52, 1'b1);
    expect_word(0, 8'h50); expect_word(0, 8'h51); expect_word(0, 8'h52);
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      step(1);
      n++;
    end
    check("t4_first_word", exp_q.size(), 2);
    bus.m_axis_tready = 1'b0;
    step(1);
    check("t4_hold_data", bus.m_axis_tdata, 8'h51);
    check("t4_hold_s_tready", bus.s_axis_tready, 0);
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!(bus.m_axis_tdata === 8'h51 && bus.m_axis_tvalid === 1'b1 &&
            bus.s_axis_tready === 4'b0000 && bus.grant_valid === 1'b1 &&
            bus.grant_id === 2'd0)) stable = 1'b0;
    end
    check("t4_hold_stable", stable, 1);
    bus.m_axis_tready = 1'b1;
    wait_drain("t4_drain", 40);

    // Mask: only ch1 and ch3 eligible; clearing ch1 mid-grant keeps the grant
    bus.chan_enable = 4'b1010;
    load(0, 8'h60, 1'b1);
    load(1, 8'h61, 1'b0); load(1, 8'h62, 1'b0); load(1, 8'h63, 1'b1);
    load(2, 8'h64, 1'b1);
    load(3, 8'h65, 1'b1);
    expect_word(1, 8'h61); expect_word(1, 8'h62); expect_word(1, 8'h63);
    expect_word(3, 8'h65);
    step(2);
    check("t5_grant_id", bus.grant_id, 1);
    bus.chan_enable = 4'b1000;
    wait_drain("t5_drain", 40);
    step(5);
    check("t5_masked_idle", bus.grant_valid, 0);
    check("t5_masked_tvalid", bus.m_axis_tvalid, 0);

    // Async reset mid-message, then first grant goes to ch0
    bus.m_axis_tready = 1'b0;
    load(3, 8'h70, 1'b0); load(3, 8'h71, 1'b0); load(3, 8'h72, 1'b1);
    step(3);
    check("t6_pre_tvalid", bus.m_axis_tvalid, 1);
    check("t6_pre_id", bus.grant_id, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_tvalid", bus.m_axis_tvalid, 0);
    check("t6_rst_s_tready", bus.s_axis_tready, 0);
    check("t6_rst_m_tdata", bus.m_axis_tdata, 0);
    check("t6_rst_grant_valid", bus.grant_valid, 0);
    check("t6_rst_grant_id", bus.grant_id, 0);
    step(3);
    rst_n = 1'b1;
    bus.chan_enable   = 4'b1111;
    bus.m_axis_tready = 1'b1;
    expect_word(0, 8'h60); expect_word(2, 8'h64);
    expect_word(3, 8'h70); expect_word(3, 8'h71); expect_word(3, 8'h72);
    step(1);
    check("t6_first_grant_valid", bus.grant_valid, 1);
    check("t6_first_grant_id", bus.grant_id, 0);
    wait_drain("t6_drain", 60);

    // Standalone picker
    pk_req = 4'b1111; pk_last = 2'd3; #1;
    check("pk_found_a", pk_found, 1); check("pk_idx_a", pk_idx, 0);
    pk_req = 4'b1111; pk_last = 2'd0; #1;
    check("pk_idx_b", pk_idx, 1);
    pk_req = 4'b1000; pk_last = 2'd0; #1;
    check("pk_idx_c", pk_idx, 3);
    pk_req = 4'b0001; pk_last = 2'd2; #1;
    check("pk_idx_wrap", pk_idx, 0);
    pk_req = 4'b0110; pk_last = 2'd1; #1;
    check("pk_idx_e", pk_idx, 2);
    pk_req = 4'b0000; pk_last = 2'd1; #1;
    check("pk_found_none", pk_found, 0);

    step(3);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter AXI-Stream input among NUM_CHANNELS independent AXI-Stream requesters, such as a CPU console, a debug logger and a status reporter.
- Arbitration is round-robin at message granularity. A grant holds until s_axis_tlast or until MAX_BURST words have been sent, whichever comes first.
- Sits directly upstream of the transmitter. m_axis_* connects to the transmitter's din_axis_* inputs.

Parameters:
NUM_CHANNELS, 4, number of requesters (2..16)
WORD_WIDTH, 8, data word width; must match the transmitter's WORD_WIDTH
MAX_BURST, 16, maximum words per grant before forced re-arbitration (1..256)
ID_WIDTH, (NUM_CHANNELS>1 ? $clog2(NUM_CHANNELS) : 1), width of grant_id (derived localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_CHANNELS*WORD_WIDTH  per-channel data; channel i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
s_axis_tvalid  in  NUM_CHANNELS  per-channel valid
s_axis_tlast  in  NUM_CHANNELS  per-channel end of message
s_axis_tready  out  NUM_CHANNELS  per-channel ready
chan_enable  in  NUM_CHANNELS  channel mask; a 0 excludes that channel from arbitration
m_axis_tdata  out  WORD_WIDTH  data to transmitter
m_axis_tvalid  out  1  valid to transmitter
m_axis_tready  in  1  ready from transmitter
grant_valid  out  1  a channel currently holds the grant
grant_id  out  ID_WIDTH  index of the granted channel; 0 when grant_valid=0

Behaviour:
- Reset is asynchronous on negedge rst_n and releases synchronously to clk.
  - state=IDLE, grant_id=0, grant_valid=0, last_id=NUM_CHANNELS-1, burst_cnt=0.
  - All outputs read 0 during reset: m_axis_tvalid, s_axis_tready, m_axis_tdata.
- Reset mid-message aborts the grant immediately. No word is emitted or accepted after rst_n falls.
- State machine, state_t:
  - IDLE: req = s_axis_tvalid & chan_enable.
    - If req != 0, pick the first set bit of req searching from last_id+1 upward, wrapping modulo NUM_CHANNELS.
    - Register the pick into grant_id, clear burst_cnt, and go to GRANT.
    - If req == 0, stay in IDLE.
  - GRANT:
    - m_axis_tvalid = s_axis_tvalid[grant_id]; m_axis_tdata = channel grant_id's data; m_axis_tlast is not provided.
    - s_axis_tready[grant_id] = m_axis_tready. All other s_axis_tready bits are 0.
    - These paths are combinational, so the arbiter adds no latency per word.
    - Handshake is m_axis_tvalid & m_axis_tready. On each handshake, burst_cnt increments.
    - If the handshake has s_axis_tlast[grant_id]=1 or burst_cnt==MAX_BURST-1:
      - Go to IDLE next cycle and set last_id <= grant_id.
      - Transfer and release occur in the same cycle.
- Arbitration latency: one cycle. The first word can transfer no earlier than the cycle after the grant is registered. Between grants there is exactly one IDLE cycle.
- grant_valid = (state==GRANT).
- chan_enable is sampled only in IDLE. Deasserting it during GRANT does not revoke the grant; the message completes.
- A granted channel that drops tvalid mid-message keeps the grant indefinitely. There is no timeout; the source owns message integrity.
- IDLE never asserts any s_axis_tready and never asserts m_axis_tvalid.
- burst_cnt is $clog2(MAX_BURST+1) bits wide and never wraps, because it clears on every grant.
- Fairness: with all channels continuously requesting, grants rotate 0,1,2,...,N-1,0. No channel waits more than N-1 grants.

Decomposition:
- Package uart_arb_pkg:
  - state_t enum {STATE_IDLE, STATE_GRANT}.
  - Function rr_next(req, last_id) returning the next index plus a found flag.
- Sub-module rr_picker: combinational, parameterised by NUM_CHANNELS. It wraps rr_next so the bench can verify it standalone.
- Top level holds the FSM, burst counter and the mux.

Test Plan:
1. Single channel: ch2 sends bytes 0x41, 0x42, 0x43 with tlast on 0x43 and m_axis_tready=1 → m_axis_tdata emits 41, 42, 43 on consecutive cycles starting 1 cycle after tvalid. grant_id=2 throughout, then grant_valid=0.
2. All 4 channels assert a 1-word message with tlast continuously → grant order 0,1,2,3,0. Each word is followed by one IDLE cycle.
3. Burst limit: MAX_BURST=4, ch1 sends 10 words with no tlast and ch3 is pending → ch1 4 words, ch3 its message, then ch1 resumes with word 5.
4. Backpressure: the transmitter holds m_axis_tready=0 for 1000 cycles mid-message → s_axis_tready[grant]=0, data is stable, no words are dropped or duplicated; transfer resumes on tready=1.
5. Mask: chan_enable=4'b1010 and all channels valid → only ch1 and ch3 are granted. Clearing bit 1 during ch1's grant still completes ch1's message.
6. Async reset: assert rst_n=0 between clock edges mid-message → outputs are 0 before the next edge. After release, the first grant goes to ch0 (last_id=N-1).
